// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage: FSM encoding,
// IF/ID payload, reset/NOP values and the MIPS opcodes decode cares about.
package fetch_unit_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned JIDX_W = 26;
  localparam int unsigned OP_W   = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc_plus4;
  } if_id_t;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;

  localparam logic [OP_W-1:0] OP_J    = 6'b000010;
  localparam logic [OP_W-1:0] OP_BEQ  = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE  = 6'b000101;
  localparam logic [OP_W-1:0] OP_LW   = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW   = 6'b101011;
  localparam logic [OP_W-1:0] OP_ADDI = 6'b001000;

  // J-type target keeps the 256 MB region of the delay-slot PC.
  function automatic logic [XLEN-1:0] jump_target(input logic [XLEN-1:0]   pc_plus4,
                                                  input logic [JIDX_W-1:0] index);
    return {pc_plus4[XLEN-1:XLEN-4], index, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register: bubble beats load, otherwise holds.
// A bubble clears the instruction and valid bit but keeps the old PC+4.
module if_id_reg
  import fetch_unit_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   load_i,
  input  logic   bubble_i,
  input  if_id_t data_i,
  output if_id_t data_o,
  output logic   valid_o
);

  if_id_t data_q;
  logic   valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q.instr    <= NOP_INSTR;
      data_q.pc_plus4 <= '0;
      valid_q         <= 1'b0;
    end else if (bubble_i) begin
      data_q.instr <= NOP_INSTR;
      valid_q      <= 1'b0;
    end else if (load_i) begin
      data_q  <= data_i;
      valid_q <= 1'b1;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, fetch FSM (IDLE/FETCH/DRAIN) and redirect
// handling, feeding the IF/ID register.
module fetch_unit
  import fetch_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              jump,
  input  logic [JIDX_W-1:0] jumpIndex,
  input  logic              branchTaken,
  input  logic [XLEN-1:0]   branchTarget,
  output logic              imemReq,
  output logic [XLEN-1:0]   imemAddr,
  input  logic              imemReady,
  input  logic [XLEN-1:0]   imemData,
  output logic [XLEN-1:0]   instrOut,
  output logic [XLEN-1:0]   pcPlus4Out,
  output logic [OP_W-1:0]   opCode,
  output logic              instrValid
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] tgt_q, tgt_d;
  logic            req_q;

  logic            redirect;
  logic [XLEN-1:0] redir_tgt;
  logic            ifid_load;
  logic            ifid_bubble;
  if_id_t          ifid_in;
  if_id_t          ifid_out;

  // Branch resolves later in the pipe than the jump decode, so it wins.
  assign redirect  = branchTaken | jump;
  assign redir_tgt = branchTaken ? branchTarget : jump_target(ifid_out.pc_plus4, jumpIndex);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      tgt_q   <= '0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      req_q   <= (state_d != ST_IDLE);
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    tgt_d       = tgt_q;
    ifid_load   = 1'b0;
    ifid_bubble = flush;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (redirect) begin
          ifid_bubble = 1'b1;
          if (imemReady) begin
            pc_d = redir_tgt;
          end else begin
            // The outstanding access must complete before the new address goes out.
            tgt_d   = redir_tgt;
            state_d = ST_DRAIN;
          end
        end else if (stall) begin
          pc_d = pc_q;
        end else if (imemReady) begin
          pc_d      = pc_q + XLEN'(4);
          ifid_load = 1'b1;
        end else begin
          ifid_bubble = 1'b1;
        end
      end
      ST_DRAIN: begin
        ifid_bubble = 1'b1;
        if (imemReady) begin
          pc_d    = tgt_q;
          state_d = ST_FETCH;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign ifid_in.instr    = imemData;
  assign ifid_in.pc_plus4 = pc_q + XLEN'(4);

  if_id_reg u_if_id (
    .clk      (clk),
    .rst      (rst),
    .load_i   (ifid_load),
    .bubble_i (ifid_bubble),
    .data_i   (ifid_in),
    .data_o   (ifid_out),
    .valid_o  (instrValid)
  );

  assign imemReq    = req_q;
  assign imemAddr   = pc_q;
  assign instrOut   = ifid_out.instr;
  assign pcPlus4Out = ifid_out.pc_plus4;
  assign opCode     = ifid_out.instr[XLEN-1:XLEN-OP_W];

endmodule
